// File: rtl/uart_program_loader_if.sv
// RAM write-port bundle driven by the program loader during boot.
// mem_we is a one-cycle write strobe with no ready: the RAM accepts every strobe.
interface uart_program_loader_if;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (output mem_we, output mem_addr, output mem_wdata);
    modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/uart_program_loader.sv
// Boot loader: receives a length-prefixed program image over 8N1 UART and writes it
// word by word into the CPU RAM, holding the CPU in reset until the image is complete.
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 2604,
    parameter int ADDR_W       = 15
) (
    input  logic                 clk,
    input  logic                 CPU_RESET,
    input  logic                 rxd,
    uart_program_loader_if.master mem,
    output logic                 cpu_reset,
    output logic                 done,
    output logic                 frame_err,
    output logic [ADDR_W:0]      words_loaded,
    output logic [3:0]           debug_state
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [1:0] LD_LEN   = 2'd0;
    localparam logic [1:0] LD_DATA  = 2'd1;
    localparam logic [1:0] LD_DONE  = 2'd2;

    logic             sync1, sync2, rx_prev;
    logic [1:0]       rx_state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic [7:0]       rx_byte;
    logic             byte_valid;

    logic [1:0]       ld_state;
    logic [1:0]       byte_cnt;
    logic [23:0]      ld_shift;
    logic [31:0]      n_words;
    logic [31:0]      index;
    logic             finish_pend;
    logic [31:0]      assembled;
    logic             in_range;

    assign assembled   = {ld_shift, rx_byte};
    assign in_range    = (index >> ADDR_W) == 32'd0;
    assign debug_state = {rx_state, ld_state};

    // Receiver: all decisions use the synchronized line, sampled near bit centres.
    always_ff @(posedge clk) begin
        if (CPU_RESET) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            rx_shift   <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync1      <= rxd;
            sync2      <= sync1;
            rx_prev    <= sync2;
            byte_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !sync2) begin
                        rx_state <= RX_START;
                        cnt      <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_M1) begin
                        cnt      <= '0;
                        bit_idx  <= '0;
                        rx_state <= sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_M1) begin
                        cnt      <= '0;
                        rx_shift <= {sync2, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_M1) begin
                        cnt      <= '0;
                        rx_state <= RX_IDLE;
                        if (sync2) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= rx_shift;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Loader: 4-byte big-endian length header, then big-endian words.
    always_ff @(posedge clk) begin
        if (CPU_RESET) begin
            ld_state      <= LD_LEN;
            byte_cnt      <= '0;
            ld_shift      <= '0;
            n_words       <= '0;
            index         <= '0;
            finish_pend   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            cpu_reset     <= 1'b1;
            done          <= 1'b0;
            words_loaded  <= '0;
        end else begin
            mem.mem_we <= 1'b0;
            // The final strobe is visible one cycle before the CPU is released.
            if (finish_pend) begin
                finish_pend <= 1'b0;
                done        <= 1'b1;
                cpu_reset   <= 1'b0;
            end
            if (byte_valid && ld_state != LD_DONE) begin
                ld_shift <= assembled[23:0];
                byte_cnt <= byte_cnt + 1'b1;
                if (byte_cnt == 2'd3) begin
                    if (ld_state == LD_LEN) begin
                        n_words <= assembled;
                        index   <= '0;
                        if (assembled == 32'd0) begin
                            ld_state  <= LD_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            ld_state  <= LD_DATA;
                        end
                    end else begin
                        // Words beyond RAM capacity are consumed but never written.
                        if (in_range) begin
                            mem.mem_we    <= 1'b1;
                            mem.mem_addr  <= 32'(index[ADDR_W-1:0]);
                            mem.mem_wdata <= assembled;
                        end
                        if (!words_loaded[ADDR_W]) words_loaded <= words_loaded + 1'b1;
                        index <= index + 32'd1;
                        if (index + 32'd1 == n_words) begin
                            ld_state    <= LD_DONE;
                            finish_pend <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for the UART program loader: serial byte driver, write scoreboard,
// and hand-computed checks of status outputs.
module tb_uart_program_loader;
  localparam int CPB = 8;
  localparam int AW  = 4;

  // clock/reset
  logic clk = 1'b0;
  logic CPU_RESET = 1'b1;
  logic rxd = 1'b1;
  always #5 clk = ~clk;

  uart_program_loader_if mem_bus ();
  logic          cpu_reset, done, frame_err;
  logic [AW:0]   words_loaded;
  logic [3:0]    debug_state;

  uart_program_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk(clk), .CPU_RESET(CPU_RESET), .rxd(rxd), .mem(mem_bus),
    .cpu_reset(cpu_reset), .done(done), .frame_err(frame_err),
    .words_loaded(words_loaded), .debug_state(debug_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];
  int last_we_cyc = -1;
  int done_rise_cyc = -1;
  int we_count = 0;
  logic done_q = 1'b0;
  logic we_prev = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write strobe must match the next expected {addr, data}
  always @(negedge clk) begin
    if (mem_bus.mem_we) begin
      logic [63:0] e;
      we_count++;
      last_we_cyc = cyc;
      check_val("we_one_cycle", 64'(we_prev), 64'(0));
      check_val("we_expected", 64'(mem_bus.mem_we), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_val("write_addr_data", {mem_bus.mem_addr, mem_bus.mem_wdata}, e);
      end
    end
    if (done && !done_q) done_rise_cyc = cyc;
    done_q  = done;
    we_prev = mem_bus.mem_we;
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    CPU_RESET = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    CPU_RESET = 1'b0;
    done_rise_cyc = -1;
    last_we_cyc = -1;
  endtask

  task automatic hold(input logic v);
    rxd = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    hold(1'b0);
    for (int i = 0; i < 8; i++) hold(b[i]);
    hold(stop_bit);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
  endtask

  task automatic push_exp(input int addr, input logic [31:0] data);
    exp_q.push_back({32'(addr), data});
  endtask

  task automatic send_image2();
    push_exp(0, 32'h3C08_0001);
    push_exp(1, 32'h2108_0005);
    send_word(32'd2);
    send_word(32'h3C08_0001);
    send_word(32'h2108_0005);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int send_end;
    int we_before;
    logic [31:0] addr_hold, data_hold;

    // 1: reset state
    do_reset();
    repeat (2) @(negedge clk);
    check_val("rst_cpu_reset", 64'(cpu_reset), 64'(1));
    check_val("rst_mem_we", 64'(mem_bus.mem_we), 64'(0));
    check_val("rst_done", 64'(done), 64'(0));
    check_val("rst_frame_err", 64'(frame_err), 64'(0));
    check_val("rst_words_loaded", 64'(words_loaded), 64'(0));
    check_val("rst_mem_addr", 64'(mem_bus.mem_addr), 64'(0));
    check_val("rst_mem_wdata", 64'(mem_bus.mem_wdata), 64'(0));

    // 2: two-word image
    send_image2();
    check_val("img2_done", 64'(done), 64'(1));
    check_val("img2_cpu_reset", 64'(cpu_reset), 64'(0));
    check_val("img2_words_loaded", 64'(words_loaded), 64'(2));
    check_val("img2_done_after_we", 64'(done_rise_cyc), 64'(last_we_cyc + 1));
    check_val("img2_frame_err", 64'(frame_err), 64'(0));
    check_val("img2_queue_empty", 64'(exp_q.size()), 64'(0));

    // 3: empty image
    do_reset();
    we_before = we_count;
    send_word(32'd0);
    send_end = cyc;
    repeat (4) @(negedge clk);
    check_val("n0_done", 64'(done), 64'(1));
    check_val("n0_cpu_reset", 64'(cpu_reset), 64'(0));
    check_val("n0_no_write", 64'(we_count), 64'(we_before));
    check_val("n0_done_latency", 64'(done_rise_cyc >= send_end && done_rise_cyc <= send_end + 2), 64'(1));

    // 4: framing error between header and data
    do_reset();
    send_word(32'd1);
    send_byte(8'h55, 1'b0);
    hold(1'b1);
    hold(1'b1);
    push_exp(0, 32'hDEAD_BEEF);
    send_word(32'hDEAD_BEEF);
    repeat (4) @(negedge clk);
    check_val("ferr_frame_err", 64'(frame_err), 64'(1));
    check_val("ferr_done", 64'(done), 64'(1));
    check_val("ferr_words_loaded", 64'(words_loaded), 64'(1));
    check_val("ferr_queue_empty", 64'(exp_q.size()), 64'(0));

    // 5: false start, then an image larger than RAM
    do_reset();
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    hold(1'b1);
    hold(1'b1);
    check_val("fs_words_loaded", 64'(words_loaded), 64'(0));
    check_val("fs_frame_err", 64'(frame_err), 64'(0));
    check_val("fs_no_write", 64'(mem_bus.mem_we), 64'(0));
    send_word(32'd17);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) push_exp(i, 32'h1000_0000 + 32'(i * 32'h0101));
      send_word(32'h1000_0000 + 32'(i * 32'h0101));
    end
    repeat (4) @(negedge clk);
    check_val("big_words_loaded", 64'(words_loaded), 64'(16));
    check_val("big_done", 64'(done), 64'(1));
    check_val("big_cpu_reset", 64'(cpu_reset), 64'(0));
    check_val("big_addr_hold", 64'(mem_bus.mem_addr), 64'(15));
    check_val("big_wdata_hold", 64'(mem_bus.mem_wdata), 64'(32'h1000_0000 + 32'(15 * 32'h0101)));
    check_val("big_queue_empty", 64'(exp_q.size()), 64'(0));

    // 6: abort mid-image, reload, then trailing bytes after done
    do_reset();
    send_word(32'd2);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h08, 1'b1);
    do_reset();
    check_val("abort_words_loaded", 64'(words_loaded), 64'(0));
    check_val("abort_cpu_reset", 64'(cpu_reset), 64'(1));
    send_image2();
    check_val("reload_words_loaded", 64'(words_loaded), 64'(2));
    check_val("reload_done", 64'(done), 64'(1));
    check_val("reload_queue_empty", 64'(exp_q.size()), 64'(0));
    addr_hold = mem_bus.mem_addr;
    data_hold = mem_bus.mem_wdata;
    we_before = we_count;
    send_word(32'h1122_3344);
    repeat (4) @(negedge clk);
    check_val("post_no_write", 64'(we_count), 64'(we_before));
    check_val("post_addr", 64'(mem_bus.mem_addr), 64'(addr_hold));
    check_val("post_wdata", 64'(mem_bus.mem_wdata), 64'(data_hold));
    check_val("post_words_loaded", 64'(words_loaded), 64'(2));
    check_val("post_done", 64'(done), 64'(1));
    check_val("post_cpu_reset", 64'(cpu_reset), 64'(0));

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
